ones_count_arbiter: RTL

ONES_COUNT_ARBITER -- requirements
Module: ones_count_arbiter

---
 rtl/ones_count_pkg.sv | 15 +
 rtl/ones_shift_counter.sv | 57 +++++
 rtl/ones_count_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ones_count_pkg.sv
// Shared types and default sizing for the ones-count arbiter.
// Build option: ONES_COUNT_ARBITER_EARLY_EXIT_EN (see ones_shift_counter).
package ones_count_pkg;

    localparam int unsigned DEF_WORD_SIZE    = 8;
    localparam int unsigned DEF_COUNTER_SIZE = 4;
    localparam int unsigned DEF_NUM_REQ      = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/ones_shift_counter.sv
// Serial ones counter: shifts the loaded word right one bit per cycle, accumulating bit 0.
// ONES_COUNT_ARBITER_EARLY_EXIT_EN ends the count once no set bits remain above bit 0.
module ones_shift_counter
    import ones_count_pkg::*;
#(
    parameter int unsigned WORD_SIZE    = DEF_WORD_SIZE,
    parameter int unsigned COUNTER_SIZE = DEF_COUNTER_SIZE
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    load_i,
    input  logic                    shift_i,
    input  logic [WORD_SIZE-1:0]    data_i,
    output logic [COUNTER_SIZE-1:0] count_next_o,
    output logic                    last_o
);

    logic [WORD_SIZE-1:0]    temp_q;
    logic [COUNTER_SIZE-1:0] count_q;

    assign count_next_o = count_q + COUNTER_SIZE'(temp_q[0]);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            temp_q  <= '0;
            count_q <= '0;
        end else if (load_i) begin
            temp_q  <= data_i;
            count_q <= '0;
        end else if (shift_i) begin
            temp_q  <= temp_q >> 1;
            count_q <= count_next_o;
        end
    end

`ifdef ONES_COUNT_ARBITER_EARLY_EXIT_EN
    // temp <= 1: this shift consumes the last bit that can still be set
    assign last_o = ((temp_q >> 1) == '0);
`else
    localparam int unsigned CW = $clog2(WORD_SIZE + 1);

    logic [CW-1:0] cyc_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cyc_q <= '0;
        end else if (load_i) begin
            cyc_q <= '0;
        end else if (shift_i) begin
            cyc_q <= cyc_q + 1'b1;
        end
    end

    assign last_o = (cyc_q == CW'(WORD_SIZE - 1));
`endif

endmodule

// File: rtl/ones_count_arbiter.sv
// Round-robin arbiter serving one requester at a time with a serial ones count of its word.
// Build option: ONES_COUNT_ARBITER_EARLY_EXIT_EN shortens service to the highest set bit.
module ones_count_arbiter
    import ones_count_pkg::*;
#(
    parameter int unsigned WORD_SIZE    = DEF_WORD_SIZE,
    parameter int unsigned COUNTER_SIZE = DEF_COUNTER_SIZE,
    parameter int unsigned NUM_REQ      = DEF_NUM_REQ
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*WORD_SIZE-1:0]   data,
    output logic [NUM_REQ-1:0]             grant,
    output logic                           busy,
    output logic [NUM_REQ-1:0]             done,
    output logic [COUNTER_SIZE-1:0]        bit_count
);

    localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e                  state_q, state_d;
    logic [NUM_REQ-1:0]      grant_q, grant_d;
    logic [NUM_REQ-1:0]      done_q, done_d;
    logic                    busy_q, busy_d;
    logic [COUNTER_SIZE-1:0] bc_q, bc_d;
    logic [PW-1:0]           ptr_q, ptr_d;

    logic                    pick_vld;
    logic [PW-1:0]           pick_idx;
    logic [PW-1:0]           pick_next;
    logic [WORD_SIZE-1:0]    pick_word;

    logic                    sc_load, sc_shift, sc_last;
    logic [COUNTER_SIZE-1:0] sc_count_next;

    // Scan from the pointer upward with wrap; first requester found wins.
    always_comb begin
        int unsigned idx;
        int unsigned nxt;
        idx       = 0;
        nxt       = 0;
        pick_vld  = 1'b0;
        pick_idx  = '0;
        pick_next = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!pick_vld && req[idx]) begin
                pick_vld = 1'b1;
                pick_idx = PW'(idx);
            end
        end
        nxt = int'(pick_idx) + 1;
        if (nxt >= NUM_REQ) nxt = 0;
        pick_next = PW'(nxt);
    end

    assign pick_word = data[pick_idx*WORD_SIZE +: WORD_SIZE];

    ones_shift_counter #(
        .WORD_SIZE    (WORD_SIZE),
        .COUNTER_SIZE (COUNTER_SIZE)
    ) u_counter (
        .clk_i        (clk),
        .rst_ni       (reset),
        .load_i       (sc_load),
        .shift_i      (sc_shift),
        .data_i       (pick_word),
        .count_next_o (sc_count_next),
        .last_o       (sc_last)
    );

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        done_d   = '0;
        busy_d   = busy_q;
        bc_d     = bc_q;
        ptr_d    = ptr_q;
        sc_load  = 1'b0;
        sc_shift = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                grant_d = '0;
                busy_d  = 1'b0;
                if (pick_vld) begin
                    state_d           = S_COUNT;
                    grant_d[pick_idx] = 1'b1;
                    busy_d            = 1'b1;
                    ptr_d             = pick_next;
                    sc_load           = 1'b1;
                end
            end
            S_COUNT: begin
                sc_shift = 1'b1;
                // Result is captured together with the final shift so it is valid alongside done.
                if (sc_last) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = grant_q;
                    bc_d    = sc_count_next;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            bc_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            bc_q    <= bc_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign bit_count = bc_q;

endmodule
